// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between an ALU (A) and a
// load (B) writeback requester, with a one-deep registered write stage and a pending bitmap.
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  A_VALID,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    output logic                  A_READY,
    input  logic                  B_VALID,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    output logic                  B_READY,
    output logic                  WRITE,
    output logic [ADDR_WIDTH-1:0] INADDRESS,
    output logic [DATA_WIDTH-1:0] IN,
    output logic [NUM_REGS-1:0]   PENDING,
    output logic [7:0]            GRANT_CNT_A,
    output logic [7:0]            GRANT_CNT_B
);

    // Handshake: a write transfers on a rising edge where VALID and READY are both 1;
    // READY is combinational and a denied requester holds VALID/ADDR/DATA until accepted.

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t                 prio_q, prio_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] inaddr_q;
    logic [DATA_WIDTH-1:0] in_q;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [7:0]            cnt_a_q, cnt_a_d;
    logic [7:0]            cnt_b_q, cnt_b_d;

    logic                  a_ready;
    logic                  b_ready;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    always_comb begin
        a_ready  = RESET && A_VALID && (!B_VALID || (prio_q == PRIO_A));
        b_ready  = RESET && B_VALID && (!A_VALID || (prio_q == PRIO_B));
        accept   = a_ready || b_ready;
        win_addr = b_ready ? B_ADDR : A_ADDR;
        win_data = b_ready ? B_DATA : A_DATA;
    end

    always_comb begin
        prio_d = prio_q;
        // A contested grant always goes to the pointer, so the loser is its opposite.
        if (RESET && A_VALID && B_VALID) begin
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (write_q) begin
            pending_d[inaddr_q] = 1'b0;
        end
        // Applied after the clear so a same-address re-accept keeps the bit set.
        if (accept) begin
            pending_d[win_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (a_ready && (cnt_a_q != 8'hFF)) begin
            cnt_a_d = cnt_a_q + 8'd1;
        end
        if (b_ready && (cnt_b_q != 8'hFF)) begin
            cnt_b_d = cnt_b_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prio_q    <= PRIO_A;
            write_q   <= 1'b0;
            inaddr_q  <= '0;
            in_q      <= '0;
            pending_q <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
        end else begin
            prio_q    <= prio_d;
            write_q   <= accept;
            pending_q <= pending_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            if (accept) begin
                inaddr_q <= win_addr;
                in_q     <= win_data;
            end
        end
    end

    assign A_READY     = a_ready;
    assign B_READY     = b_ready;
    assign WRITE       = write_q;
    assign INADDRESS   = inaddr_q;
    assign IN          = in_q;
    assign PENDING     = pending_q;
    assign GRANT_CNT_A = cnt_a_q;
    assign GRANT_CNT_B = cnt_b_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: queued requesters, a behavioural grant model feeding
// an expected-write queue, and a negedge monitor that pops and compares stage outputs.
module tb_reg_write_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          write;
  logic [AW-1:0] inaddress;
  logic [DW-1:0] in_data;
  logic [NR-1:0] pending;
  logic [7:0]    cnt_a, cnt_b;

  reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .CLK(clk), .RESET(rst_n),
    .A_VALID(a_valid), .A_ADDR(a_addr), .A_DATA(a_data), .A_READY(a_ready),
    .B_VALID(b_valid), .B_ADDR(b_addr), .B_DATA(b_data), .B_READY(b_ready),
    .WRITE(write), .INADDRESS(inaddress), .IN(in_data), .PENDING(pending),
    .GRANT_CNT_A(cnt_a), .GRANT_CNT_B(cnt_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // requester queues ({addr, data}), scoreboard, reference state
  logic [AW+DW-1:0] a_q[$];
  logic [AW+DW-1:0] b_q[$];
  logic [AW+DW-1:0] exp_q[$];
  bit               glog[$];       // 0 = A granted, 1 = B granted
  bit               prio_b;        // requester that wins the next contest
  int               m_cnt_a, m_cnt_b;
  logic [DW-1:0]    rf[NR];
  bit               mon_en = 1'b0;
  int               total = 0;
  int               bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // driver: present queue fronts, holding them until granted
  task automatic drive();
    a_valid = (a_q.size() > 0);
    b_valid = (b_q.size() > 0);
    if (a_valid) {a_addr, a_data} = a_q[0];
    if (b_valid) {b_addr, b_data} = b_q[0];
  endtask

  // reference grant decision for the upcoming edge
  task automatic model_step();
    bit av, bv, ga, gb;
    av = (a_q.size() > 0);
    bv = (b_q.size() > 0);
    ga = 1'b0;
    gb = 1'b0;
    if (av && bv) begin
      if (prio_b) gb = 1'b1; else ga = 1'b1;
      prio_b = ga;
    end else if (av) begin
      ga = 1'b1;
    end else if (bv) begin
      gb = 1'b1;
    end
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    if (ga) begin
      exp_q.push_back(a_q.pop_front());
      glog.push_back(1'b0);
      if (m_cnt_a < 255) m_cnt_a++;
    end
    if (gb) begin
      exp_q.push_back(b_q.pop_front());
      glog.push_back(1'b1);
      if (m_cnt_b < 255) m_cnt_b++;
    end
  endtask

  // one cycle, starting and ending 1 time unit after a falling edge
  task automatic cycle();
    drive();
    #1;
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input bit expect_write);
    if (expect_write) chk("write_before_reset", write, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_write", write, 0);
    chk("rst_pending", pending, 0);
    a_q.delete();
    b_q.delete();
    exp_q.delete();
    glog.delete();
    prio_b  = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_glog(input string name, input int n, input logic [7:0] pattern);
    logic [7:0] got;
    got = '0;
    for (int i = 0; i < n && i < glog.size(); i++) got[i] = glog[i];
    chk({name, "_len"}, glog.size(), n);
    chk(name, got, pattern);
  endtask

  // monitor: pop and compare whenever the stage presents (or should present) a write
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write", write, 1);
        chk("inaddress", inaddress, e[AW+DW-1:DW]);
        chk("in", in_data, e[DW-1:0]);
        chk("pending", pending, 32'(1) << e[AW+DW-1:DW]);
      end else begin
        chk("write_idle", write, 0);
        chk("pending_idle", pending, 0);
      end
      chk("cnt_a", cnt_a, m_cnt_a);
      chk("cnt_b", cnt_b, m_cnt_b);
      if (write) rf[inaddress] = in_data;
    end
  end

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_addr  = '0;
    b_addr  = '0;
    a_data  = '0;
    b_data  = '0;
    prio_b  = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    for (int i = 0; i < NR; i++) rf[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_write", write, 0);
    chk("reset_inaddress", inaddress, 0);
    chk("reset_in", in_data, 0);
    chk("reset_pending", pending, 0);
    chk("reset_cnt_a", cnt_a, 0);
    chk("reset_cnt_b", cnt_b, 0);
    chk("reset_a_ready", a_ready, 0);
    chk("reset_b_ready", b_ready, 0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;

    // single A write
    a_q.push_back({3'd2, 8'd77});
    run(3);
    chk("t1_cnt_a", cnt_a, 1);

    // contested alternation with distinct addresses
    do_reset(1'b0);
    repeat (2) begin
      a_q.push_back({3'd1, 8'($urandom_range(0, 255))});
      b_q.push_back({3'd5, 8'($urandom_range(0, 255))});
    end
    run(5);
    chk_glog("t2_order", 4, 8'b1010);
    chk("t2_cnt_a", cnt_a, 2);
    chk("t2_cnt_b", cnt_b, 2);

    // same-address contention: A first, B last wins
    do_reset(1'b0);
    a_q.push_back({3'd3, 8'd10});
    b_q.push_back({3'd3, 8'd20});
    run(3);
    chk_glog("t3_order", 2, 8'b10);
    chk("t3_reg3", rf[3], 20);

    // uncontested B grants leave the pointer on A
    do_reset(1'b0);
    repeat (3) b_q.push_back({3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))});
    run(3);
    a_q.push_back({3'd6, 8'd11});
    b_q.push_back({3'd7, 8'd22});
    run(3);
    chk_glog("t4_order", 5, 8'b10111);

    // reset during an in-flight write
    do_reset(1'b0);
    a_q.push_back({3'd4, 8'd99});
    cycle();
    do_reset(1'b1);
    run(3);

    // counter saturation
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) a_q.push_back({3'(i), 8'(i * 7)});
    run(302);
    chk("t6_cnt_a_sat", cnt_a, 255);

    // randomized traffic
    do_reset(1'b0);
    for (int i = 0; i < 250; i++) begin
      if (a_q.size() < 2 && $urandom_range(0, 2) != 0)
        a_q.push_back({3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))});
      if (b_q.size() < 2 && $urandom_range(0, 2) != 0)
        b_q.push_back({3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))});
      cycle();
    end
    run(6);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
